moxie_bus_arbiter: RTL and testbench

- Shares the single Wishbone master port of the moxie core between the instruction-fetch requester and the data (load/store) requester.
- Holds one transaction in flight at a time, arbitrates round-robin when both requesters contend, and returns read data plus a one-cycle acknowledge to the winning requester.
- Sits between the fetch/memory stages and the external Wishbone bus.

---
 rtl/moxie_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_moxie_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moxie_bus_arbiter.sv
// Round-robin arbiter sharing the moxie Wishbone master port between instruction fetch and
// load/store. Define MOXIE_ARB_TIMEOUT_EN to abort bus cycles that never receive wb_ack_i.
module moxie_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned TIMEOUT_W      = 5
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ireq_i,
   input  logic [31:0] iadr_i,
   output logic [31:0] idat_o,
   output logic        iack_o,
   output logic        ierr_o,
   input  logic        dreq_i,
   input  logic        dwe_i,
   input  logic [3:0]  dsel_i,
   input  logic [31:0] dadr_i,
   input  logic [31:0] ddat_i,
   output logic [31:0] ddat_o,
   output logic        dack_o,
   output logic        derr_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS_I, S_BUS_D, S_DONE} state_e;
   typedef enum logic {GNT_I, GNT_D} grant_e;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
      $error("moxie_bus_arbiter: TIMEOUT_W cannot hold TIMEOUT_CYCLES");
   end

   state_e      state_q, state_d;
   grant_e      last_grant_q, last_grant_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        cyc_q, cyc_d;
   logic [31:0] idat_q, idat_d;
   logic [31:0] ddat_q, ddat_d;
   logic        iack_q, iack_d;
   logic        ierr_q, ierr_d;
   logic        dack_q, dack_d;
   logic        derr_q, derr_d;
   logic        timeout_hit;

`ifdef MOXIE_ARB_TIMEOUT_EN
   logic                 in_bus;
   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   assign in_bus = (state_q == S_BUS_I) || (state_q == S_BUS_D);

   // Counter sits at zero outside BUS_*, so it is already cleared on entry.
   always_comb begin
      tmo_cnt_d = '0;
      if (in_bus && !wb_ack_i) tmo_cnt_d = tmo_cnt_q + 1'b1;
   end

   assign timeout_hit = in_bus && !wb_ack_i &&
                        (tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) tmo_cnt_q <= '0;
      else       tmo_cnt_q <= tmo_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      adr_d        = adr_q;
      wdat_d       = wdat_q;
      sel_d        = sel_q;
      we_d         = we_q;
      cyc_d        = cyc_q;
      idat_d       = '0;
      ddat_d       = '0;
      iack_d       = 1'b0;
      ierr_d       = 1'b0;
      dack_d       = 1'b0;
      derr_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Under contention the requester not served last wins.
            if (ireq_i && (!dreq_i || last_grant_q == GNT_D)) begin
               state_d      = S_BUS_I;
               last_grant_d = GNT_I;
               adr_d        = iadr_i;
               wdat_d       = '0;
               sel_d        = 4'hF;
               we_d         = 1'b0;
               cyc_d        = 1'b1;
            end else if (dreq_i) begin
               state_d      = S_BUS_D;
               last_grant_d = GNT_D;
               adr_d        = dadr_i;
               wdat_d       = ddat_i;
               sel_d        = dsel_i;
               we_d         = dwe_i;
               cyc_d        = 1'b1;
            end
         end
         S_BUS_I, S_BUS_D: begin
            // A late ack in the expiry cycle still completes normally.
            if (wb_ack_i || timeout_hit) begin
               cyc_d   = 1'b0;
               state_d = S_DONE;
               if (state_q == S_BUS_I) begin
                  iack_d = wb_ack_i;
                  ierr_d = !wb_ack_i;
                  idat_d = wb_ack_i ? wb_dat_i : '0;
               end else begin
                  dack_d = wb_ack_i;
                  derr_d = !wb_ack_i;
                  ddat_d = wb_ack_i ? wb_dat_i : '0;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         last_grant_q <= GNT_D;
         adr_q        <= '0;
         wdat_q       <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         cyc_q        <= 1'b0;
         idat_q       <= '0;
         ddat_q       <= '0;
         iack_q       <= 1'b0;
         ierr_q       <= 1'b0;
         dack_q       <= 1'b0;
         derr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         adr_q        <= adr_d;
         wdat_q       <= wdat_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         cyc_q        <= cyc_d;
         idat_q       <= idat_d;
         ddat_q       <= ddat_d;
         iack_q       <= iack_d;
         ierr_q       <= ierr_d;
         dack_q       <= dack_d;
         derr_q       <= derr_d;
      end
   end

   assign wb_adr_o = adr_q;
   assign wb_dat_o = wdat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign idat_o   = idat_q;
   assign iack_o   = iack_q;
   assign ierr_o   = ierr_q;
   assign ddat_o   = ddat_q;
   assign dack_o   = dack_q;
   assign derr_o   = derr_q;

endmodule

// File: tb/tb_moxie_bus_arbiter.sv
// Self-checking bench for moxie_bus_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model of grant order, latency and returned data.
module tb_moxie_bus_arbiter;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        we;
   } xfer_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ireq_i, dreq_i, dwe_i, wb_ack_i;
   logic [31:0] iadr_i, dadr_i, ddat_i, wb_dat_i;
   logic [3:0]  dsel_i;
   logic [31:0] idat_o, ddat_o, wb_adr_o, wb_dat_o;
   logic        iack_o, ierr_o, dack_o, derr_o, wb_we_o, wb_cyc_o, wb_stb_o;
   logic [3:0]  wb_sel_o;

   int n_checks = 0;
   int n_pass   = 0;

   moxie_bus_arbiter dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ireq_i(ireq_i), .iadr_i(iadr_i), .idat_o(idat_o), .iack_o(iack_o), .ierr_o(ierr_o),
      .dreq_i(dreq_i), .dwe_i(dwe_i), .dsel_i(dsel_i), .dadr_i(dadr_i), .ddat_i(ddat_i),
      .ddat_o(ddat_o), .dack_o(dack_o), .derr_o(derr_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      ireq_i = 0; iadr_i = 0; dreq_i = 0; dwe_i = 0; dsel_i = 0; dadr_i = 0; ddat_i = 0;
      wb_dat_i = 0; wb_ack_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1;
      step();
      step();
      rst_i = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      ireq_i = 1; dreq_i = 1; wb_ack_i = 1; iadr_i = 32'h1234_5678;
      rst_i = 1;
      step();
      step();
      n_checks++;
      if ({idat_o, iack_o, ierr_o, ddat_o, dack_o, derr_o, wb_adr_o, wb_dat_o, wb_sel_o,
           wb_we_o, wb_cyc_o, wb_stb_o} !== '0)
         $display("FAIL reset_outputs: got cyc=%b adr=%h iack=%b dack=%b, want all zero",
                  wb_cyc_o, wb_adr_o, iack_o, dack_o);
      else n_pass++;
      idle_inputs();
      rst_i = 0;
      step();
      step();
      n_checks++;
      if ({wb_cyc_o, iack_o, dack_o} !== 3'b000)
         $display("FAIL reset_idle_no_req: got cyc/iack/dack=%b want 000", {wb_cyc_o, iack_o, dack_o});
      else n_pass++;
   endtask

   task automatic test_instr_read();
      do_reset();
      ireq_i = 1; iadr_i = 32'h1000;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {3'b110, 4'hF, 32'h1000, 32'h0})
         $display("FAIL instr_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 1 0 f 00001000 0",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
      else n_pass++;
      step();
      n_checks++;
      if ({wb_cyc_o, iack_o, wb_adr_o} !== {2'b10, 32'h1000})
         $display("FAIL instr_wait_hold: got cyc=%b iack=%b adr=%h want 1 0 00001000", wb_cyc_o, iack_o, wb_adr_o);
      else n_pass++;
      wb_ack_i = 1; wb_dat_i = 32'hDEAD_BEEF;
      step();
      n_checks++;
      if ({wb_cyc_o, iack_o, ierr_o, dack_o, idat_o, ddat_o} !== {4'b0100, 32'hDEAD_BEEF, 32'h0})
         $display("FAIL instr_ack: got cyc=%b iack=%b ierr=%b dack=%b idat=%h ddat=%h want 0 1 0 0 deadbeef 0",
                  wb_cyc_o, iack_o, ierr_o, dack_o, idat_o, ddat_o);
      else n_pass++;
      ireq_i = 0; wb_ack_i = 0; wb_dat_i = 0;
      step();
      n_checks++;
      if ({wb_cyc_o, iack_o, idat_o} !== 34'h0)
         $display("FAIL instr_after_done: got cyc=%b iack=%b idat=%h want 0 0 0", wb_cyc_o, iack_o, idat_o);
      else n_pass++;
      step();
   endtask

   task automatic test_data_write();
      do_reset();
      dreq_i = 1; dwe_i = 1; dsel_i = 4'b0011; dadr_i = 32'h2004; ddat_i = 32'h0000_ABCD;
      wb_ack_i = 0;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {3'b111, 4'b0011, 32'h2004, 32'h0000_ABCD})
         $display("FAIL data_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h want 1 1 1 3 00002004 0000abcd",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
      else n_pass++;
      wb_ack_i = 1; wb_dat_i = 32'h0;
      step();
      n_checks++;
      if ({wb_cyc_o, dack_o, derr_o, iack_o} !== 4'b0100)
         $display("FAIL data_ack: got cyc/dack/derr/iack=%b want 0100", {wb_cyc_o, dack_o, derr_o, iack_o});
      else n_pass++;
      // Next request presented right after the ack: DONE then IDLE, so it starts two edges later.
      wb_ack_i = 0; dwe_i = 0; dadr_i = 32'h2008; dsel_i = 4'hF;
      step();
      n_checks++;
      if ({wb_cyc_o, dack_o} !== 2'b00)
         $display("FAIL data_done_ignores_req: got cyc/dack=%b want 00", {wb_cyc_o, dack_o});
      else n_pass++;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 32'h2008})
         $display("FAIL data_next_start: got cyc=%b we=%b adr=%h want 1 0 00002008", wb_cyc_o, wb_we_o, wb_adr_o);
      else n_pass++;
      wb_ack_i = 1;
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_contention();
      int phase;
      logic d_turn;
      logic [31:0] exp_idat, exp_ddat;
      do_reset();
      ireq_i = 1; iadr_i = 32'hA000;
      dreq_i = 1; dwe_i = 0; dsel_i = 4'hC; dadr_i = 32'hB000; ddat_i = 32'h5555;
      wb_ack_i = 1;
      for (int i = 0; i < 12; i++) begin
         wb_dat_i = 32'hC0DE_0000 + i;
         step();
         phase    = i % 3;
         d_turn   = ((i / 3) % 2) == 1;
         exp_idat = (phase == 1 && !d_turn) ? wb_dat_i : 32'h0;
         exp_ddat = (phase == 1 && d_turn) ? wb_dat_i : 32'h0;
         n_checks++;
         if ({wb_cyc_o, iack_o, dack_o, idat_o, ddat_o} !==
             {phase == 0, phase == 1 && !d_turn, phase == 1 && d_turn, exp_idat, exp_ddat})
            $display("FAIL contention_seq i=%0d: got cyc=%b iack=%b dack=%b idat=%h ddat=%h want %b %b %b %h %h",
                     i, wb_cyc_o, iack_o, dack_o, idat_o, ddat_o, phase == 0,
                     phase == 1 && !d_turn, phase == 1 && d_turn, exp_idat, exp_ddat);
         else n_pass++;
         if (phase == 0) begin
            n_checks++;
            if (wb_adr_o !== (d_turn ? 32'hB000 : 32'hA000))
               $display("FAIL contention_grant i=%0d: got adr=%h want %h", i, wb_adr_o, d_turn ? 32'hB000 : 32'hA000);
            else n_pass++;
         end
      end
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_spurious_ack();
      do_reset();
      wb_ack_i = 1; wb_dat_i = 32'h7777_7777;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({wb_cyc_o, iack_o, dack_o, ierr_o, derr_o} !== 5'b0)
            $display("FAIL spurious_ack i=%0d: got cyc/iack/dack/ierr/derr=%b want 00000", i,
                     {wb_cyc_o, iack_o, dack_o, ierr_o, derr_o});
         else n_pass++;
      end
      wb_ack_i = 0; ireq_i = 1; iadr_i = 32'h0C00;
      step();
      step();
      n_checks++;
      if ({wb_cyc_o, iack_o, wb_adr_o} !== {2'b10, 32'h0C00})
         $display("FAIL spurious_then_req: got cyc=%b iack=%b adr=%h want 1 0 00000c00", wb_cyc_o, iack_o, wb_adr_o);
      else n_pass++;
      wb_ack_i = 1;
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      dreq_i = 1; dwe_i = 1; dsel_i = 4'hF; dadr_i = 32'h3000; ddat_i = 32'h1234;
      step();
      step();
      n_checks++;
      if ({wb_cyc_o, wb_we_o} !== 2'b11)
         $display("FAIL reset_mid_busd: got cyc/we=%b want 11", {wb_cyc_o, wb_we_o});
      else n_pass++;
      rst_i = 1; wb_ack_i = 1; wb_dat_i = 32'hFFFF_FFFF; ireq_i = 1; iadr_i = 32'h4000;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, dack_o, derr_o, ddat_o} !== 36'h0)
         $display("FAIL reset_mid_abort: got cyc=%b stb=%b dack=%b derr=%b ddat=%h want all 0",
                  wb_cyc_o, wb_stb_o, dack_o, derr_o, ddat_o);
      else n_pass++;
      rst_i = 0; wb_ack_i = 0;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h4000})
         $display("FAIL reset_mid_last_grant: got cyc=%b adr=%h want 1 00004000", wb_cyc_o, wb_adr_o);
      else n_pass++;
      wb_ack_i = 1;
      step();
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_timeout();
      int  high;
      logic bad;
      do_reset();
      dreq_i = 1; dwe_i = 0; dsel_i = 4'h1; dadr_i = 32'h5000;
      wb_dat_i = 32'h9999_9999;
      step();
      high = (wb_cyc_o === 1'b1) ? 1 : 0;
      bad  = 1'b0;
`ifdef MOXIE_ARB_TIMEOUT_EN
      for (int j = 1; j < 16; j++) begin
         step();
         if (wb_cyc_o === 1'b1) high++;
         if (derr_o !== 1'b0 || dack_o !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (high != 16 || bad)
         $display("FAIL timeout_window: got cyc high %0d cycles (early resp=%b) want 16 (0)", high, bad);
      else n_pass++;
      step();
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, derr_o, dack_o, ddat_o} !== {4'b0010, 32'h0})
         $display("FAIL timeout_err: got cyc=%b stb=%b derr=%b dack=%b ddat=%h want 0 0 1 0 0",
                  wb_cyc_o, wb_stb_o, derr_o, dack_o, ddat_o);
      else n_pass++;
      dreq_i = 0;
      step();
      n_checks++;
      if ({wb_cyc_o, derr_o} !== 2'b00)
         $display("FAIL timeout_err_once: got cyc/derr=%b want 00", {wb_cyc_o, derr_o});
      else n_pass++;
      dreq_i = 1;
      step();
      for (int j = 1; j < 16; j++) step();
      wb_ack_i = 1; wb_dat_i = 32'h6161_6161;
      step();
      n_checks++;
      if ({dack_o, derr_o, ddat_o} !== {2'b10, 32'h6161_6161})
         $display("FAIL timeout_ack_wins: got dack=%b derr=%b ddat=%h want 1 0 61616161", dack_o, derr_o, ddat_o);
      else n_pass++;
`else
      for (int j = 1; j <= 40; j++) begin
         step();
         if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) high++;
         if (derr_o !== 1'b0 || dack_o !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (high != 41 || bad)
         $display("FAIL no_timeout_wait: got cyc high %0d cycles (resp=%b) want 41 (0)", high, bad);
      else n_pass++;
      wb_ack_i = 1; wb_dat_i = 32'h6161_6161;
      step();
      n_checks++;
      if ({dack_o, derr_o, ddat_o} !== {2'b10, 32'h6161_6161})
         $display("FAIL no_timeout_ack: got dack=%b derr=%b ddat=%h want 1 0 61616161", dack_o, derr_o, ddat_o);
      else n_pass++;
`endif
      idle_inputs();
      step();
      step();
   endtask

   // Transaction-level reference: a start may occur once two edges have passed since the last
   // response; the winner is the sole requester or the one not served last; data follows the ack.
   task automatic test_random();
      logic        busy, owner_d, last_d, exp_iack, exp_dack;
      logic [31:0] exp_idat, exp_ddat;
      xfer_t       cur;
      int          earliest, wait_n, fails_at_start;
      do_reset();
      busy = 0; owner_d = 0; last_d = 1; earliest = 0; wait_n = 0; cur = '0;
      fails_at_start = n_checks - n_pass;
      for (int e = 0; e < 3000; e++) begin
         if (!ireq_i || iack_o) begin
            ireq_i = ($urandom_range(2, 0) != 0);
            iadr_i = $urandom();
         end
         if (!dreq_i || dack_o) begin
            dreq_i = ($urandom_range(2, 0) != 0);
            dwe_i  = $urandom_range(1, 0) == 1;
            dsel_i = 4'($urandom_range(15, 0));
            dadr_i = $urandom();
            ddat_i = $urandom();
         end
         wb_dat_i = $urandom();
         if (busy) wb_ack_i = (wait_n >= 8) || ($urandom_range(2, 0) == 0);
         else      wb_ack_i = ($urandom_range(7, 0) == 0);
         exp_iack = 0; exp_dack = 0; exp_idat = 0; exp_ddat = 0;
         if (busy && wb_ack_i) begin
            busy = 0;
            if (owner_d) begin exp_dack = 1; exp_ddat = wb_dat_i; end
            else         begin exp_iack = 1; exp_idat = wb_dat_i; end
            earliest = e + 2;
         end else if (busy) begin
            wait_n++;
         end else if (e >= earliest && (ireq_i || dreq_i)) begin
            owner_d = dreq_i && (!ireq_i || !last_d);
            last_d  = owner_d;
            busy    = 1;
            wait_n  = 0;
            cur     = owner_d ? xfer_t'{dadr_i, ddat_i, dsel_i, dwe_i} : xfer_t'{iadr_i, 32'h0, 4'hF, 1'b0};
         end
         step();
         n_checks++;
         if ({wb_cyc_o, wb_stb_o, iack_o, dack_o, ierr_o, derr_o} !== {busy, busy, exp_iack, exp_dack, 2'b00})
            $display("FAIL rand_ctrl edge %0d: got cyc/stb/iack/dack/ierr/derr=%b want %b", e,
                     {wb_cyc_o, wb_stb_o, iack_o, dack_o, ierr_o, derr_o},
                     {busy, busy, exp_iack, exp_dack, 2'b00});
         else n_pass++;
         n_checks++;
         if ({idat_o, ddat_o} !== {exp_idat, exp_ddat})
            $display("FAIL rand_data edge %0d: got idat=%h ddat=%h want %h %h", e, idat_o, ddat_o, exp_idat, exp_ddat);
         else n_pass++;
         if (busy) begin
            n_checks++;
            if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== cur)
               $display("FAIL rand_bus edge %0d: got adr=%h dat=%h sel=%h we=%b want %h %h %h %b", e,
                        wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, cur.adr, cur.dat, cur.sel, cur.we);
            else n_pass++;
         end
         if (n_checks - n_pass - fails_at_start > 20) break;
      end
      idle_inputs();
   endtask

   initial begin
      rst_i = 1;
      idle_inputs();
      test_reset();
      test_instr_read();
      test_data_write();
      test_contention();
      test_spurious_ack();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
